// File: rtl/mips6_cpu.sv
// Multi-cycle 16-bit core for a six-instruction ISA; each instruction runs FETCH -> DECODE -> EXEC.
// Optional: define MIPS6_HALT_EN to make opcode 1111 halt the core until reset.
module mips6_cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic [15:0] r_data,
    output logic        i_rd,
    output logic        d_rd,
    output logic        d_wr,
    output logic [15:0] i_addr,
    output logic [15:0] d_addr,
    output logic [15:0] w_data
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_rf [16];

    logic [3:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [7:0]  w_d8;
    logic [15:0] w_sext;

    assign w_op   = r_ir[15:12];
    assign w_ra   = r_ir[11:8];
    assign w_rb   = r_ir[7:4];
    assign w_rc   = r_ir[3:0];
    assign w_d8   = r_ir[7:0];
    assign w_sext = {{8{w_d8[7]}}, w_d8};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= 16'h0000;
            end
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    r_ir    <= i_data;
                    r_pc    <= r_pc + 16'd1;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (w_op)
                        4'h0: r_rf[w_ra] <= r_data;
                        4'h2: r_rf[w_ra] <= r_rf[w_rb] + r_rf[w_rc];
                        4'h3: r_rf[w_ra] <= w_sext;
                        4'h4: r_rf[w_ra] <= r_rf[w_rb] - r_rf[w_rc];
                        // PC already points past the JMPZ, so step back one to get its own address
                        4'h5: if (r_rf[w_ra] == 16'h0000) r_pc <= r_pc - 16'd1 + w_sext;
`ifdef MIPS6_HALT_EN
                        4'hF: r_state <= S_HALT;
`endif
                        default: ;
                    endcase
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // Strobes are decoded straight from state and forced low while reset is held.
    assign i_rd   = ~rst & (r_state == S_FETCH);
    assign d_rd   = ~rst & (r_state == S_EXEC) & (w_op == 4'h0);
    assign d_wr   = ~rst & (r_state == S_EXEC) & (w_op == 4'h1);
    assign i_addr = r_pc;
    assign d_addr = {8'h00, w_d8};
    assign w_data = r_rf[w_ra];

endmodule

// File: tb/tb_mips6_cpu.sv
// Bench for mips6_cpu: an instruction-level ISA model runs beside the core and is compared cycle by cycle.
module tb_mips6_cpu;

    logic        clk;
    logic        rst;
    logic [15:0] i_data;
    logic [15:0] r_data;
    logic        i_rd;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic [15:0] w_data;

    logic [15:0] prog   [65536];
    logic [15:0] dmem   [256];
    logic [15:0] m_dmem [256];
    logic [15:0] m_rf   [16];
    logic [15:0] m_pc;
    bit          m_halt;
    int          n_chk;
    int          n_err;

    mips6_cpu #(.RESET_PC(16'h0000)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_data),
        .r_data (r_data),
        .i_rd   (i_rd),
        .d_rd   (d_rd),
        .d_wr   (d_wr),
        .i_addr (i_addr),
        .d_addr (d_addr),
        .w_data (w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_data = prog[i_addr];
    assign r_data = d_rd ? dmem[d_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (d_wr) dmem[d_addr[7:0]] = w_data;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rst_on();
        @(posedge clk);
        #1 rst = 1'b1;
        m_pc   = 16'h0000;
        m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        #10;
        chk("rst_strobes", {13'd0, i_rd, d_rd, d_wr}, 16'h0000);
        chk("rst_pc", i_addr, 16'h0000);
    endtask

    task automatic rst_off();
        #12 rst = 1'b0;
    endtask

    // One instruction of the ISA model, checked against the core over its three cycles.
    task automatic run_instr();
        logic [15:0] ir;
        logic [15:0] sx;
        logic [15:0] here;
        logic [3:0]  op, ra, rb, rc;
        logic [7:0]  d8;
        logic [15:0] ex;
        @(negedge clk);
        chk("fetch_strobes", {13'd0, i_rd, d_rd, d_wr}, 16'h0004);
        chk("fetch_pc", i_addr, m_pc);
        ir   = prog[m_pc];
        op   = ir[15:12];
        ra   = ir[11:8];
        rb   = ir[7:4];
        rc   = ir[3:0];
        d8   = ir[7:0];
        sx   = {{8{d8[7]}}, d8};
        here = m_pc;
        m_pc = m_pc + 16'd1;
        @(negedge clk);
        chk("decode_strobes", {13'd0, i_rd, d_rd, d_wr}, 16'h0000);
        @(negedge clk);
        ex = (op == 4'h0) ? 16'h0002 : (op == 4'h1) ? 16'h0001 : 16'h0000;
        chk("exec_strobes", {13'd0, i_rd, d_rd, d_wr}, ex);
        chk("d_addr", d_addr, {8'h00, d8});
        chk("w_data", w_data, m_rf[ra]);
        case (op)
            4'h0: m_rf[ra] = m_dmem[d8];
            4'h1: m_dmem[d8] = m_rf[ra];
            4'h2: m_rf[ra] = m_rf[rb] + m_rf[rc];
            4'h3: m_rf[ra] = sx;
            4'h4: m_rf[ra] = m_rf[rb] - m_rf[rc];
            4'h5: if (m_rf[ra] == 16'h0000) m_pc = here + sx;
`ifdef MIPS6_HALT_EN
            4'hF: m_halt = 1'b1;
`endif
            default: ;
        endcase
    endtask

    task automatic load_jmp(input logic [15:0] ldc, input logic [15:0] jmp);
        rst_on();
        prog[0] = ldc;
        for (int a = 1; a < 5; a++) prog[a] = 16'h3900;
        prog[5] = jmp;
        rst_off();
        repeat (6) run_instr();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] op;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int a = 0; a < 65536; a++) prog[a] = 16'h3900;
        for (int a = 0; a < 256; a++) begin
            dmem[a]   = 16'h0000;
            m_dmem[a] = 16'h0000;
        end

        // Random programs with random data memory.
        rst_on();
        for (int a = 0; a < 65536; a++) begin
            op = 4'($urandom_range(0, 15));
`ifdef MIPS6_HALT_EN
            if (op == 4'hF) op = 4'hE;
`endif
            prog[a] = {op, 12'($urandom)};
        end
        for (int a = 0; a < 256; a++) begin
            dmem[a]   = 16'($urandom);
            m_dmem[a] = dmem[a];
        end
        rst_off();
        repeat (300) run_instr();
        @(posedge clk);
        #1;
        for (int a = 0; a < 256; a++) chk("rand_dmem", dmem[a], m_dmem[a]);

        // Reset clears every register: STORE R5 -> 0 writes zero.
        rst_on();
        dmem[0]   = 16'hBEEF;
        m_dmem[0] = 16'hBEEF;
        prog[0]   = 16'h1500;
        rst_off();
        run_instr();
        @(posedge clk);
        #1 chk("rst_rf_zero", dmem[0], 16'h0000);

        // LDC R1,#-3 ; STORE R1->10 : write strobe on cycle 6.
        rst_on();
        prog[0] = 16'h31FD;
        prog[1] = 16'h110A;
        rst_off();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("first_i_rd", {15'd0, i_rd}, 16'h0001);
        end
        chk("c6_d_wr", {15'd0, d_wr}, 16'h0001);
        chk("c6_d_addr", d_addr, 16'h000A);
        chk("c6_w_data", w_data, 16'hFFFD);

        // Overflow wrap on ADD and SUB.
        rst_on();
        dmem[20] = 16'h7FFF; m_dmem[20] = 16'h7FFF;
        prog[0] = 16'h0214;
        prog[1] = 16'h3301;
        prog[2] = 16'h2423;
        prog[3] = 16'h1415;
        prog[4] = 16'h4532;
        prog[5] = 16'h1516;
        rst_off();
        repeat (6) run_instr();
        @(posedge clk);
        #1;
        chk("add_wrap", dmem[21], 16'h8000);
        chk("sub_wrap", dmem[22], 16'h8002);

        // Jumps: forward taken, not taken, backward taken.
        load_jmp(16'h3600, 16'h5603);
        chk("jmpz_fwd", i_addr, 16'h0008);
        load_jmp(16'h3601, 16'h5603);
        chk("jmpz_not", i_addr, 16'h0006);
        load_jmp(16'h3600, 16'h56FE);
        chk("jmpz_back", i_addr, 16'h0003);

        // Fibonacci F(7) with a SUB/JMPZ loop counter.
        rst_on();
        dmem[255] = 16'h0000; m_dmem[255] = 16'h0000;
        prog[0]  = 16'h3100;
        prog[1]  = 16'h3201;
        prog[2]  = 16'h3306;
        prog[3]  = 16'h3401;
        prog[4]  = 16'h3000;
        prog[5]  = 16'h2512;
        prog[6]  = 16'h2120;
        prog[7]  = 16'h2250;
        prog[8]  = 16'h4334;
        prog[9]  = 16'h5302;
        prog[10] = 16'h50FB;
        prog[11] = 16'h12FF;
        prog[12] = 16'h5000;
        rst_off();
        repeat (41) run_instr();
        @(posedge clk);
        #1 chk("fib_result", dmem[255], 16'h000D);

`ifdef MIPS6_HALT_EN
        // HALT freezes the core until reset.
        rst_on();
        prog[0] = 16'h3105;
        prog[1] = 16'h3900;
        prog[2] = 16'hF000;
        rst_off();
        repeat (3) run_instr();
        chk("halt_model", {15'd0, m_halt}, 16'h0001);
        repeat (20) begin
            @(negedge clk);
            chk("halt_i_rd", {15'd0, i_rd}, 16'h0000);
            chk("halt_pc", i_addr, 16'h0003);
        end
        rst_on();
        rst_off();
        @(negedge clk);
        chk("halt_restart_rd", {15'd0, i_rd}, 16'h0001);
        chk("halt_restart_pc", i_addr, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
